row_interleave_out: RTL and testbench

Parametrised output row buffer sitting between the kernel's block-parallel datapath and the outbound image stream. Each input beat carries one band-wide slice per lane. Each slice is pushed into that lane's private FWFT FIFO. Rows are then drained one lane at a time in round-robin order, producing a single BAND_WIDTH stream with row/frame framing, ready/valid backpressure on both sides, per-lane write masking for partial final row groups, and sticky overflow detection.

---
 rtl/row_interleave_out_if.sv | 28 ++
 rtl/row_interleave_out.sv | 208 ++++++++++++++++++++
 tb/tb_row_interleave_out.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/row_interleave_out_if.sv
// Stream bundle for row_interleave_out: wide multi-lane input side, single-band
// output side, flush and overflow status. The DUT takes the slave modport.
interface row_interleave_out_if #(
    parameter int BAND_WIDTH = 512,
    parameter int LANES      = 4
);
    logic                          i_clear;
    logic [LANES*BAND_WIDTH-1:0]   i_im_data;
    logic                          i_im_vld;
    logic [LANES-1:0]              i_im_lane_en;
    logic                          o_im_rdy;
    logic [BAND_WIDTH-1:0]         o_im_data;
    logic                          o_im_vld;
    logic                          i_im_out_rdy;
    logic                          o_im_out_last_row;
    logic                          o_im_out_last;
    logic                          o_overflow;

    modport master (
        output i_clear, i_im_data, i_im_vld, i_im_lane_en, i_im_out_rdy,
        input  o_im_rdy, o_im_data, o_im_vld, o_im_out_last_row, o_im_out_last, o_overflow
    );

    modport slave (
        input  i_clear, i_im_data, i_im_vld, i_im_lane_en, i_im_out_rdy,
        output o_im_rdy, o_im_data, o_im_vld, o_im_out_last_row, o_im_out_last, o_overflow
    );
endinterface

// File: rtl/row_interleave_out.sv
// Per-lane FWFT row buffers drained lane by lane in round-robin into one band stream.
// Define ROW_INTERLEAVE_REG_OUT_EN to add a 2-entry skid register after the lane mux.
module row_interleave_out #(
    parameter int BAND_WIDTH    = 512,
    parameter int LANES         = 4,
    parameter int FIFO_DEPTH    = 128,
    parameter int AFULL_MARGIN  = 4,
    parameter int IM_WIDTH      = 800,
    parameter int IM_HEIGHT     = 800,
    parameter int IM_DATA_WIDTH = 8,
    parameter int IM_CHN_CNT    = 4
) (
    input logic           clk,
    input logic           rst_n,
    row_interleave_out_if.slave bus
);
    localparam int COL_CNT = IM_WIDTH * IM_DATA_WIDTH * IM_CHN_CNT / BAND_WIDTH;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = $clog2(COL_CNT);
    localparam int RW      = (IM_HEIGHT > 1) ? $clog2(IM_HEIGHT) : 1;
    localparam int LW      = $clog2(LANES);

    logic [BAND_WIDTH-1:0] mem_q [LANES][FIFO_DEPTH];
    logic [AW:0]           wr_ptr_q [LANES];
    logic [AW:0]           rd_ptr_q [LANES];
    logic [AW:0]           cnt      [LANES];
    logic [BAND_WIDTH-1:0] dout     [LANES];
    logic [LANES-1:0]      full, empty, afull, push, pop;
    logic                  blocked, push_ok, ovf_q;

    logic [CW-1:0] p_col_q, p_col_d;
    logic [RW-1:0] p_row_q, p_row_d;
    logic [LW-1:0] p_lane_q, p_lane_d;
    logic [CW-1:0] out_col;
    logic [RW-1:0] out_row;

    logic                  pop_fire, mux_vld, txfer;
    logic [BAND_WIDTH-1:0] mux_data;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            cnt[k]   = wr_ptr_q[k] - rd_ptr_q[k];
            full[k]  = (cnt[k] == (AW+1)'(FIFO_DEPTH));
            empty[k] = (cnt[k] == '0);
            afull[k] = (cnt[k] >= (AW+1)'(FIFO_DEPTH - AFULL_MARGIN));
            dout[k]  = mem_q[k][rd_ptr_q[k][AW-1:0]];
            pop[k]   = pop_fire && (p_lane_q == LW'(k));
        end
    end

    // Full is the registered flag, so a pop in the same cycle cannot free a slot.
    assign blocked  = |(bus.i_im_lane_en & full);
    assign push_ok  = bus.i_im_vld & ~blocked & ~bus.i_clear;
    assign push     = {LANES{push_ok}} & bus.i_im_lane_en;
    assign mux_vld  = ~empty[p_lane_q];
    assign mux_data = dout[p_lane_q];

    assign bus.o_im_rdy   = ~|afull;
    assign bus.o_overflow = ovf_q;

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LANES; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
            end
        end else if (bus.i_clear) begin
            for (int k = 0; k < LANES; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < LANES; k++) begin
                if (push[k]) wr_ptr_q[k] <= wr_ptr_q[k] + (AW+1)'(1);
                if (pop[k])  rd_ptr_q[k] <= rd_ptr_q[k] + (AW+1)'(1);
            end
        end
    end

    // NOTE: storage is not reset; pointers alone decide which entries are meaningful.
    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (push[k]) mem_q[k][wr_ptr_q[k][AW-1:0]] <= bus.i_im_data[k*BAND_WIDTH +: BAND_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            ovf_q <= 1'b0;
        else if (bus.i_clear)                  ovf_q <= 1'b0;
        else if (bus.i_im_vld && blocked)      ovf_q <= 1'b1;
    end

    // Pop-side position: selects the lane and moves on after each row's last pop.
    always_comb begin
        p_col_d  = p_col_q;
        p_row_d  = p_row_q;
        p_lane_d = p_lane_q;
        if (pop_fire) begin
            if (p_col_q == CW'(COL_CNT - 1)) begin
                p_col_d = '0;
                if (p_row_q == RW'(IM_HEIGHT - 1)) begin
                    p_row_d  = '0;
                    p_lane_d = '0;
                end else begin
                    p_row_d  = p_row_q + RW'(1);
                    p_lane_d = (p_lane_q == LW'(LANES - 1)) ? '0 : p_lane_q + LW'(1);
                end
            end else begin
                p_col_d = p_col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_col_q  <= '0;
            p_row_q  <= '0;
            p_lane_q <= '0;
        end else if (bus.i_clear) begin
            p_col_q  <= '0;
            p_row_q  <= '0;
            p_lane_q <= '0;
        end else begin
            p_col_q  <= p_col_d;
            p_row_q  <= p_row_d;
            p_lane_q <= p_lane_d;
        end
    end

`ifdef ROW_INTERLEAVE_REG_OUT_EN
    logic [BAND_WIDTH-1:0] out_data_q, out_data_d, skid_data_q, skid_data_d;
    logic                  out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
    logic [CW-1:0]         o_col_q, o_col_d;
    logic [RW-1:0]         o_row_q, o_row_d;

    assign pop_fire      = mux_vld & ~skid_vld_q;
    assign txfer         = out_vld_q & bus.i_im_out_rdy;
    assign bus.o_im_data = out_data_q;
    assign bus.o_im_vld  = out_vld_q;
    assign out_col       = o_col_q;
    assign out_row       = o_row_q;

    // Output flop refills from the skid entry first, else straight from the mux.
    always_comb begin
        out_data_d  = out_data_q;
        out_vld_d   = out_vld_q;
        skid_data_d = skid_data_q;
        skid_vld_d  = skid_vld_q;
        if (!out_vld_q || bus.i_im_out_rdy) begin
            if (skid_vld_q) begin
                out_data_d = skid_data_q;
                out_vld_d  = 1'b1;
                skid_vld_d = 1'b0;
            end else begin
                out_vld_d = mux_vld;
                if (mux_vld) out_data_d = mux_data;
            end
        end else if (pop_fire) begin
            skid_data_d = mux_data;
            skid_vld_d  = 1'b1;
        end
    end

    always_comb begin
        o_col_d = o_col_q;
        o_row_d = o_row_q;
        if (txfer) begin
            if (o_col_q == CW'(COL_CNT - 1)) begin
                o_col_d = '0;
                o_row_d = (o_row_q == RW'(IM_HEIGHT - 1)) ? '0 : o_row_q + RW'(1);
            end else begin
                o_col_d = o_col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || bus.i_clear) begin
            out_data_q  <= '0;
            out_vld_q   <= 1'b0;
            skid_data_q <= '0;
            skid_vld_q  <= 1'b0;
            o_col_q     <= '0;
            o_row_q     <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_vld_q   <= out_vld_d;
            skid_data_q <= skid_data_d;
            skid_vld_q  <= skid_vld_d;
            o_col_q     <= o_col_d;
            o_row_q     <= o_row_d;
        end
    end
`else
    assign pop_fire      = mux_vld & bus.i_im_out_rdy;
    assign txfer         = pop_fire;
    assign bus.o_im_data = mux_data;
    assign bus.o_im_vld  = mux_vld;
    assign out_col       = p_col_q;
    assign out_row       = p_row_q;
`endif

    assign bus.o_im_out_last_row = txfer && (out_col == CW'(COL_CNT - 1));
    assign bus.o_im_out_last     = bus.o_im_out_last_row && (out_row == RW'(IM_HEIGHT - 1));

endmodule

// File: tb/tb_row_interleave_out.sv
// Directed bench for row_interleave_out: framing, backpressure, overflow and clear.
module tb_row_interleave_out;
    localparam int BW = 128;
    localparam int NL = 4;
`ifdef ROW_INTERLEAVE_REG_OUT_EN
    localparam bit REG_OUT = 1'b1;
`else
    localparam bit REG_OUT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    row_interleave_out_if #(.BAND_WIDTH(BW), .LANES(NL)) bus ();

    row_interleave_out #(
        .BAND_WIDTH(BW), .LANES(NL), .FIFO_DEPTH(8), .AFULL_MARGIN(2),
        .IM_WIDTH(16), .IM_HEIGHT(6), .IM_DATA_WIDTH(8), .IM_CHN_CNT(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mk(input int k, input int w);
        return {64'(k), 64'(w)};
    endfunction

    // Beat i of a frame: row i/4 comes from lane row%4, carrying write group row/4.
    function automatic logic [127:0] exp_beat(input int base, input int i);
        int r = i / 4;
        int c = i % 4;
        return mk(r % 4, base + (r / 4) * 4 + c);
    endfunction

    task automatic put(input int w, input logic [3:0] en, input logic clr);
        @(negedge clk);
        bus.i_im_vld     = 1'b1;
        bus.i_im_lane_en = en;
        bus.i_clear      = clr;
        for (int k = 0; k < NL; k++) bus.i_im_data[k*BW +: BW] = mk(k, w);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.i_im_vld = 1'b0;
        bus.i_clear  = 1'b0;
    endtask

    task automatic drain(input int n, input int base, input bit alt, input string tag);
        int got = 0;
        int cyc = 0;
        bit r = 1'b1;
        bit stall = 1'b0;
        while (got < n && cyc < 200) begin
            @(negedge clk);
            bus.i_im_out_rdy = r;
            #1;
            if (stall) check({tag, "_hold_vld"}, bus.o_im_vld, 1'b1);
            if (bus.o_im_vld) check({tag, "_data"}, bus.o_im_data, exp_beat(base, got));
            if (bus.o_im_vld && r) begin
                check({tag, "_last_row"}, bus.o_im_out_last_row, (got % 4) == 3);
                check({tag, "_last"}, bus.o_im_out_last, got == 23);
                got++;
            end else begin
                check({tag, "_no_last_row"}, bus.o_im_out_last_row, 1'b0);
            end
            stall = bus.o_im_vld && !r;
            if (alt) r = !r;
            cyc++;
        end
        check({tag, "_count"}, got, n);
        if (!alt) check({tag, "_cycles"}, cyc, n);
        @(negedge clk);
        bus.i_im_out_rdy = 1'b0;
    endtask

    initial begin
        bus.i_clear      = 1'b0;
        bus.i_im_data    = '0;
        bus.i_im_vld     = 1'b0;
        bus.i_im_lane_en = '0;
        bus.i_im_out_rdy = 1'b0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("rst_vld", bus.o_im_vld, 1'b0);
        check("rst_rdy", bus.o_im_rdy, 1'b1);
        check("rst_ovf", bus.o_overflow, 1'b0);
        check("rst_last_row", bus.o_im_out_last_row, 1'b0);
        check("rst_last", bus.o_im_out_last, 1'b0);

        // Frame 1: full row group then partial group on lanes 0-1, drained at full rate.
        for (int w = 0; w < 8; w++) begin
            put(w, (w < 4) ? 4'b1111 : 4'b0011, 1'b0);
            #1;
            if (w == 0) check("lat_w0", bus.o_im_vld, 1'b0);
            if (w == 1) check("lat_w1", bus.o_im_vld, !REG_OUT);
            if (w == 2) check("lat_w2", bus.o_im_vld, 1'b1);
        end
        idle();
        drain(24, 0, 1'b0, "f1");
        #1;
        check("f1_empty", bus.o_im_vld, 1'b0);

        // Frame 2: same content, downstream ready toggling every cycle.
        for (int w = 0; w < 8; w++) put(w, (w < 4) ? 4'b1111 : 4'b0011, 1'b0);
        idle();
        drain(24, 0, 1'b1, "f2");
        #1;
        check("f2_empty", bus.o_im_vld, 1'b0);
        check("f2_ovf", bus.o_overflow, 1'b0);

        // Overflow: nine all-lane writes with output stalled.
        for (int j = 1; j <= 9; j++) begin
            put(15 + j, 4'b1111, 1'b0);
            #1;
            check($sformatf("ovf_rdy_w%0d", j), bus.o_im_rdy, (j - 1) < 6);
            check($sformatf("ovf_flag_w%0d", j), bus.o_overflow, 1'b0);
        end
        idle();
        #1;
        check("ovf_set", bus.o_overflow, 1'b1);
        check("ovf_rdy_low", bus.o_im_rdy, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        check("ovf_sticky", bus.o_overflow, 1'b1);

        drain(10, 16, 1'b0, "f3");

        // Clear with a coincident beat: everything flushed, beat dropped, flag cleared.
        put(99, 4'b1111, 1'b1);
        idle();
        #1;
        check("clr_vld", bus.o_im_vld, 1'b0);
        check("clr_ovf", bus.o_overflow, 1'b0);
        check("clr_rdy", bus.o_im_rdy, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        check("clr_dropped", bus.o_im_vld, 1'b0);

        for (int w = 32; w < 36; w++) put(w, 4'b1111, 1'b0);
        idle();
        drain(4, 32, 1'b0, "f4");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
